// File: rtl/xbar_ingress_tx.sv
// Crossbar ingress: FIFO of {dest,data} words, each presented one at a time to the
// output arbiter of its destination and sent into the crossbar once granted.
module xbar_ingress_tx #(
    parameter int width      = 8,
    parameter int depth      = 8,
    parameter int starve_lim = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [width-1:0]         s_data,
    input  logic [1:0]               s_dest,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [3:0]               req,
    input  logic [3:0]               gnt,
    output logic [width-1:0]         xb_data,
    output logic                     xb_valid,
    output logic [$clog2(depth):0]   count,
    output logic                     starve,
    output logic                     err
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

    state_t               state, state_nxt;
    logic [width+1:0]     mem [depth];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [width+1:0]     head;
    logic [CW-1:0]        count_nxt;
    logic [7:0]           wait_cnt, wait_nxt;
    logic                 push, pop, spurious;

    function automatic logic [3:0] dest_onehot(input logic [1:0] d);
        return 4'b0001 << d;
    endfunction

    assign s_ready  = (count != CW'(depth));
    assign push     = s_valid && s_ready;
    assign head     = mem[rd_ptr];
    // Any grant bit we did not ask for is an arbiter fault; it never pops.
    assign spurious = |(gnt & ~req);

    always_comb begin
        state_nxt = state;
        req       = 4'b0000;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) state_nxt = REQ;
            end
            REQ: begin
                req = dest_onehot(head[width+1:width]);
                if (|(gnt & req)) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                state_nxt = (count != '0) ? REQ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + CW'(1);
        else if (pop && !push) count_nxt = count - CW'(1);
    end

    always_comb begin
        wait_nxt = 8'd0;
        if (state == REQ && !pop)
            wait_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            xb_valid <= 1'b0;
            xb_data  <= '0;
            wait_cnt <= 8'd0;
            starve   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            wait_cnt <= wait_nxt;
            starve   <= (wait_nxt >= 8'(starve_lim));
            err      <= err | spurious;
            xb_valid <= pop;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                xb_data <= head[width-1:0];
            end
        end
    end

    // Storage has no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= {s_dest, s_data};
    end
endmodule

// File: doc/xbar_ingress_tx.md
XBAR_INGRESS_TX -- requirements
Module: xbar_ingress_tx

Interface
REQ-001 Parameter: width, 8, data bits per word.
REQ-002 Parameter: depth, 8, FIFO entries; power of two, 2 to 64.
REQ-003 Parameter: starve_lim, 16, wait cycles in REQ before starve asserts; 1 to 255.
REQ-004 Port: clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: s_data  in  width  upstream word.
REQ-007 Port: s_dest  in  2  destination output port (0-3) of s_data.
REQ-008 Port: s_valid  in  1  upstream word present.
REQ-009 Port: s_ready  out  1  block accepts word; equals !full.
REQ-010 Port: req  out  4  one-hot request to the output arbiter of the head word's destination.
REQ-011 Port: gnt  in  4  one-hot grant from the output arbiters, same-cycle response to req.
REQ-012 Port: xb_data  out  width  word driven into the crossbar input.
REQ-013 Port: xb_valid  out  1  xb_data valid, one-cycle pulse per word.
REQ-014 Port: count  out  log2(depth)+1  FIFO occupancy.
REQ-015 Port: starve  out  1  head word waited >= starve_lim cycles.
REQ-016 Port: err  out  1  sticky spurious-grant flag.

Function
REQ-017 The FIFO shall store {dest,data}; a push occurs when s_valid && s_ready; count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-018 s_ready shall be 0 when count==depth, including in a cycle in which a pop occurs; pointers wrap modulo depth.
REQ-019 The FSM shall have states IDLE, REQ, and SEND; state and all outputs except req and s_ready are registered.
REQ-020 IDLE: req=0; go to REQ on the edge after count becomes nonzero. A word pushed at edge N drives req at cycle N+1 and the state reads REQ.
REQ-021 REQ: req = one-hot(head dest). If gnt & req is nonzero, the next edge shall pop the head, load xb_data with head data, set xb_valid=1, and go to SEND.
REQ-022 SEND: req=0; xb_valid drops after one cycle; next state is REQ if count is nonzero after the pop, else IDLE. Sustained throughput is 1 word per 2 cycles.
REQ-023 xb_data shall hold its last value when xb_valid=0.
REQ-024 Latency: grant seen at cycle M gives xb_valid=1 at cycle M+1; an empty FIFO with a push at edge N gives earliest xb_valid at N+2.
REQ-025 wait_cnt shall increment each REQ cycle without a matching grant and saturate at 255; it clears on a matching grant or on leaving REQ. starve = (wait_cnt >= starve_lim).
REQ-026 err shall set when gnt has any bit outside req (including any gnt in IDLE or SEND) and remain set until reset; spurious bits shall not cause a pop.
REQ-027 Words shall leave in push order regardless of destination (head-of-line blocking by design).

Reset
REQ-028 While rst=1 at an edge: state=IDLE, pointers=0, count=0, xb_valid=0, xb_data=0, wait_cnt=0, starve=0, err=0. req=0 and s_ready=1 the cycle after.
REQ-029 Reset mid-transfer shall discard all FIFO contents; no xb_valid pulse shall follow reset unless a new word is pushed and granted.
REQ-030 Pushes presented while rst=1 shall be ignored.

Verification
REQ-031 Push AA to dest 1 at edge N, gnt=4'b0010 whenever req=4'b0010 -> req=0010 at N+1, xb_valid=1 and xb_data=AA at N+2, count=0, state IDLE at N+3.
REQ-032 Push BB, CC, DD, EE to dests 3, 0, 2, 3 with always-grant -> xb_data sequence BB, CC, DD, EE, each xb_valid pulse 2 cycles apart, req sequence 1000, 0001, 0100, 1000.
REQ-033 Push 8 words with gnt held 0 -> count=8, s_ready=0, ninth push blocked; starve=1 from 16 cycles after req asserted; grant once -> starve=0 next cycle, count=7, s_ready=1.
REQ-034 Full FIFO, s_valid=1, grant at the same edge -> pop only, no push, count=7.
REQ-035 gnt=4'b0100 while req=4'b0001 -> err=1 sticky, no pop, count unchanged; the flag is cleared only by rst.
REQ-036 3 words queued, rst pulsed one cycle mid-SEND -> count=0, xb_valid=0, req=0, no further output without new pushes.
